// File: rtl/mailbox_pkg.sv
// Shared constants for the Wishbone mailbox: register offsets, STATUS bit positions
// and IRQ_EN bit positions.
package mailbox_pkg;

    typedef enum logic [1:0] {
        ADR_DATA   = 2'd0,
        ADR_STATUS = 2'd1,
        ADR_IRQEN  = 2'd2,
        ADR_OVF    = 2'd3
    } reg_off_e;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 12;

    localparam int IRQ_RX_NONEMPTY = 0;
    localparam int IRQ_TX_EMPTY    = 1;

endpackage

// File: rtl/wb_mailbox_responder_if.sv
// Wishbone B4 classic bus bundle between the crossbar (master) and the mailbox (slave).
interface wb_mailbox_responder_if;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_wb_err;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_dat, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/mailbox_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; pushes into a full FIFO and
// pops from an empty one are ignored.
module mailbox_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; empty/count gate every read, so only pointers need one.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/wb_mailbox_responder.sv
// Wishbone mailbox: TX/RX FIFOs, STATUS, IRQ_EN and level interrupt.
// Define MAILBOX_OVF_CNT_EN to map a saturating overflow counter at offset 0xC.
module wb_mailbox_responder
    import mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_2000,
    parameter int          DEPTH    = 8,
    parameter int          PTR_W    = $clog2(DEPTH)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    wb_mailbox_responder_if.slave         wb,
    output logic [31:0]                   o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    input  logic [31:0]                   i_rx_data,
    input  logic                          i_rx_valid,
    output logic                          o_rx_ready,
    output logic                          o_irq
);
    logic        ack_q, ack_d, err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  irq_en_q, irq_en_d;
    logic        irq_q, irq_d;

    logic             req, hit;
    reg_off_e         off;
    logic [31:0]      status;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [PTR_W:0]   tx_count, rx_count;
    logic [31:0]      rx_head;
    logic             unused_bits;

    assign req = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q & ~err_q;
    assign hit = (wb.i_wb_adr[31:4] == BASE_ADR[31:4]);
    assign off = reg_off_e'(wb.i_wb_adr[3:2]);
    assign unused_bits = ^{wb.i_wb_adr[1:0], wb.i_wb_sel[3:1]};

    assign tx_pop     = o_tx_valid & i_tx_ready;
    assign o_tx_valid = ~tx_empty;
    assign rx_push    = i_rx_valid & o_rx_ready;
    assign o_rx_ready = ~rx_full;

    mailbox_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .push(tx_push), .din(wb.i_wb_dat), .pop(tx_pop), .dout(o_tx_data),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    mailbox_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .push(rx_push), .din(i_rx_data), .pop(rx_pop), .dout(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        status = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_TX_CNT_LSB +: 4] = 4'(tx_count);
        status[ST_RX_CNT_LSB +: 4] = 4'(rx_count);
    end

`ifdef MAILBOX_OVF_CNT_EN
    logic [15:0] ovf_q, ovf_d;
    logic        ovf_inc, ovf_clr;

    assign ovf_inc = (req & hit & (off == ADR_DATA) & wb.i_wb_we & tx_full)
                   | (i_rx_valid & rx_full);
    assign ovf_clr = req & hit & (off == ADR_OVF) & wb.i_wb_we;

    // Clear wins over a same-cycle increment; the count saturates at all-ones.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)                      ovf_d = '0;
        else if (ovf_inc && ~&ovf_q)      ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) ovf_q <= '0;
        else            ovf_q <= ovf_d;
    end
`endif

    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    always_comb begin
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        irq_en_d = irq_en_q;
        if (req) begin
            if (!hit) begin
                err_d = 1'b1;
            end else begin
                case (off)
                    ADR_DATA: begin
                        if (wb.i_wb_we) begin
                            if (tx_full) err_d = 1'b1;
                            else begin
                                tx_push = 1'b1;
                                ack_d   = 1'b1;
                            end
                        end else begin
                            ack_d = 1'b1;
                            if (!rx_empty) begin
                                rx_pop = 1'b1;
                                dat_d  = rx_head;
                            end
                        end
                    end
                    ADR_STATUS: begin
                        ack_d = 1'b1;
                        if (!wb.i_wb_we) dat_d = status;
                    end
                    ADR_IRQEN: begin
                        ack_d = 1'b1;
                        if (wb.i_wb_we) begin
                            if (wb.i_wb_sel[0]) irq_en_d = wb.i_wb_dat[1:0];
                        end else begin
                            dat_d = {30'b0, irq_en_q};
                        end
                    end
                    ADR_OVF: begin
`ifdef MAILBOX_OVF_CNT_EN
                        ack_d = 1'b1;
                        if (!wb.i_wb_we) dat_d = {16'h0, ovf_q};
`else
                        err_d = 1'b1;
`endif
                    end
                endcase
            end
        end
    end

    assign irq_d = (irq_en_q[IRQ_RX_NONEMPTY] & ~rx_empty)
                 | (irq_en_q[IRQ_TX_EMPTY] & tx_empty);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_err = err_q;
    assign wb.o_wb_dat = dat_q;
    assign o_irq       = irq_q;

endmodule

// File: tb/tb_wb_mailbox_responder.sv
// Directed bench for wb_mailbox_responder: bus accesses, FIFO streams, IRQ and reset.
// Covers the MAILBOX_OVF_CNT_EN build when that macro is defined.
module tb_wb_mailbox_responder;

    localparam logic [31:0] BASE   = 32'h3000_2000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_IRQ  = BASE + 32'h8;
    localparam logic [31:0] A_OVF  = BASE + 32'hC;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        o_irq;

    int tests = 0;
    int fails = 0;

    wb_mailbox_responder_if wb ();

    wb_mailbox_responder dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .wb         (wb),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_irq      (o_irq)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus access; returns termination flags, read data and latency in cycles.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, output logic [31:0] rdat,
                        output logic ack, output logic err, output int lat);
        @(negedge i_clk);
        wb.i_wb_adr = adr; wb.i_wb_dat = wdat; wb.i_wb_sel = sel; wb.i_wb_we = we;
        wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1;
        lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge i_clk); #1;
            if (wb.o_wb_ack || wb.o_wb_err) begin
                ack = wb.o_wb_ack; err = wb.o_wb_err; rdat = wb.o_wb_dat; lat = i;
                break;
            end
        end
        check("term_seen", {31'b0, lat != 0}, 32'd1);
        wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel,
                      input logic exp_err, input string tag);
        logic [31:0] r; logic a, e; int l;
        xfer(1'b1, adr, d, sel, r, a, e, l);
        check(tag, {30'b0, a, e}, exp_err ? 32'd1 : 32'd2);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp_dat,
                      input logic exp_err, input string tag);
        logic [31:0] r; logic a, e; int l;
        xfer(1'b0, adr, 32'h0, 4'hF, r, a, e, l);
        check({tag, "_term"}, {30'b0, a, e}, exp_err ? 32'd1 : 32'd2);
        check({tag, "_dat"}, r, exp_dat);
    endtask

    task automatic host_push(input logic [31:0] d);
        @(negedge i_clk);
        i_rx_valid = 1'b1; i_rx_data = d;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r; logic a, e; int l;
        i_reset_n = 1'b1;
        wb.i_wb_adr = '0; wb.i_wb_dat = '0; wb.i_wb_sel = '0;
        wb.i_wb_we = 1'b0; wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
        i_tx_ready = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;

        #3 i_reset_n = 1'b0;
        #4;
        check("rst_ack",   {31'b0, wb.o_wb_ack}, 32'd0);
        check("rst_err",   {31'b0, wb.o_wb_err}, 32'd0);
        check("rst_dat",   wb.o_wb_dat, 32'd0);
        check("rst_txv",   {31'b0, o_tx_valid}, 32'd0);
        check("rst_rxrdy", {31'b0, o_rx_ready}, 32'd1);
        check("rst_irq",   {31'b0, o_irq}, 32'd0);
        @(negedge i_clk); @(negedge i_clk);
        i_reset_n = 1'b1;

        // Single TX write with the host stalled
        xfer(1'b1, A_DATA, 32'hDEAD_BEEF, 4'hF, r, a, e, l);
        check("t1_term", {30'b0, a, e}, 32'd2);
        check("t1_lat", l, 32'd1);
        check("t1_txv", {31'b0, o_tx_valid}, 32'd1);
        check("t1_txd", o_tx_data, 32'hDEAD_BEEF);
        rd(A_STAT, 32'h0000_0108, 1'b0, "t1_status");  // tx_count=1, rx_empty
        @(negedge i_clk); i_tx_ready = 1'b1;
        @(negedge i_clk); i_tx_ready = 1'b0;
        check("t1_drained", {31'b0, o_tx_valid}, 32'd0);

        // Fill TX, overflow write, then drain in order
        for (int i = 1; i <= 8; i++) wr(A_DATA, i, 4'hF, 1'b0, "t2_push");
        wr(A_DATA, 32'd9, 4'hF, 1'b1, "t2_ninth_err");
        rd(A_STAT, 32'h0000_0809, 1'b0, "t2_status");
        @(negedge i_clk); i_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("t2_txv", {31'b0, o_tx_valid}, 32'd1);
            check("t2_txd", o_tx_data, i);
            @(negedge i_clk);
        end
        i_tx_ready = 1'b0;
        check("t2_empty", {31'b0, o_tx_valid}, 32'd0);

        // RX: two words then a read from the empty FIFO
        host_push(32'h11);
        host_push(32'h22);
        rd(A_DATA, 32'h11, 1'b0, "t3_rd0");
        rd(A_DATA, 32'h22, 1'b0, "t3_rd1");
        rd(A_DATA, 32'h0,  1'b0, "t3_rd_empty");
        rd(A_STAT, 32'h0000_000A, 1'b0, "t3_status");

        // RX full: ready drops, extra word is not stored
        for (int i = 0; i < 8; i++) host_push(32'h100 + i);
        check("rx_full_rdy", {31'b0, o_rx_ready}, 32'd0);
        host_push(32'h1FF);
        rd(A_STAT, 32'h0000_8006, 1'b0, "rx_full_status");
        for (int i = 0; i < 8; i++) rd(A_DATA, 32'h100 + i, 1'b0, "rx_full_rd");
        rd(A_DATA, 32'h0, 1'b0, "rx_after_full");
        check("rx_rdy_back", {31'b0, o_rx_ready}, 32'd1);

        // Interrupt sources and IRQ_EN byte-lane gating
        wr(A_IRQ, 32'd1, 4'hF, 1'b0, "irq_en1");
        check("irq_idle", {31'b0, o_irq}, 32'd0);
        host_push(32'h33);
        @(posedge i_clk); #1;
        check("irq_rx", {31'b0, o_irq}, 32'd1);
        rd(A_DATA, 32'h33, 1'b0, "irq_pop");
        check("irq_rx_clr", {31'b0, o_irq}, 32'd0);
        wr(A_IRQ, 32'd2, 4'hF, 1'b0, "irq_en2");
        check("irq_tx_empty", {31'b0, o_irq}, 32'd1);
        rd(A_IRQ, 32'd2, 1'b0, "irq_en_rd");
        wr(A_IRQ, 32'd0, 4'hE, 1'b0, "irq_en_nosel");
        rd(A_IRQ, 32'd2, 1'b0, "irq_en_kept");
        wr(A_IRQ, 32'd0, 4'hF, 1'b0, "irq_en0");

        // Same-cycle host push and CPU pop with three entries held
        host_push(32'hA1); host_push(32'hA2); host_push(32'hA3);
        @(negedge i_clk);
        i_rx_valid = 1'b1; i_rx_data = 32'hA4;
        wb.i_wb_adr = A_DATA; wb.i_wb_we = 1'b0; wb.i_wb_sel = 4'hF;
        wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1;
        @(posedge i_clk); #1;
        check("pp_ack", {31'b0, wb.o_wb_ack}, 32'd1);
        check("pp_dat", wb.o_wb_dat, 32'hA1);
        i_rx_valid = 1'b0; wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
        @(posedge i_clk); #1;
        rd(A_STAT, 32'h0000_3002, 1'b0, "pp_status");
        rd(A_DATA, 32'hA2, 1'b0, "pp_rd2");
        rd(A_DATA, 32'hA3, 1'b0, "pp_rd3");
        rd(A_DATA, 32'hA4, 1'b0, "pp_rd4");

        // Address decode errors
        wr(32'h3000_3000, 32'h55, 4'hF, 1'b1, "miss_wr");
        rd(32'h3000_3000, 32'h0, 1'b1, "miss_rd");
        check("miss_no_push", {31'b0, o_tx_valid}, 32'd0);
        rd(A_STAT, 32'h0000_000A, 1'b0, "miss_status");
`ifdef MAILBOX_OVF_CNT_EN
        wr(A_OVF, 32'h0, 4'hF, 1'b0, "ovf_clr0");
        for (int i = 0; i < 8; i++) wr(A_DATA, 32'h200 + i, 4'hF, 1'b0, "ovf_fill");
        wr(A_DATA, 32'h2FE, 4'hF, 1'b1, "ovf_drop1");
        wr(A_DATA, 32'h2FF, 4'hF, 1'b1, "ovf_drop2");
        rd(A_OVF, 32'd2, 1'b0, "ovf_cnt2");
        wr(A_OVF, 32'h1234, 4'hF, 1'b0, "ovf_clr");
        rd(A_OVF, 32'd0, 1'b0, "ovf_cnt0");
        @(negedge i_clk); i_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge i_clk);
        i_tx_ready = 1'b0;
        check("ovf_drained", {31'b0, o_tx_valid}, 32'd0);
`else
        rd(A_OVF, 32'h0, 1'b1, "adr_c_rd_err");
        wr(A_OVF, 32'h0, 4'hF, 1'b1, "adr_c_wr_err");
`endif

        // Asynchronous reset with an ack pending and the interrupt raised
        host_push(32'h77);
        wr(A_IRQ, 32'd1, 4'hF, 1'b0, "rst_irq_en");
        check("rst_pre_irq", {31'b0, o_irq}, 32'd1);
        @(negedge i_clk);
        wb.i_wb_adr = A_DATA; wb.i_wb_we = 1'b0; wb.i_wb_sel = 4'hF;
        wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1;
        wb.i_wb_dat = 32'h0;
        @(posedge i_clk); #1;
        check("rst_pre_ack", {31'b0, wb.o_wb_ack}, 32'd1);
        check("rst_pre_dat", wb.o_wb_dat, 32'h77);
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_ack",   {31'b0, wb.o_wb_ack}, 32'd0);
        check("mid_rst_err",   {31'b0, wb.o_wb_err}, 32'd0);
        check("mid_rst_dat",   wb.o_wb_dat, 32'd0);
        check("mid_rst_txv",   {31'b0, o_tx_valid}, 32'd0);
        check("mid_rst_rxrdy", {31'b0, o_rx_ready}, 32'd1);
        check("mid_rst_irq",   {31'b0, o_irq}, 32'd0);
        wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
        @(negedge i_clk); i_reset_n = 1'b1;
        rd(A_IRQ, 32'd0, 1'b0, "post_rst_irqen");
        rd(A_STAT, 32'h0000_000A, 1'b0, "post_rst_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
